// File: rtl/ram_read_ctrl_if.sv
// ram_read_ctrl_if -- bundles the readout controller's control inputs and its
// BRAM-side / serialiser-side outputs.
//
//   slave  : the readout controller (ram_read_ctrl)
//   master : whatever drives the controls and consumes the outputs
//
// Signals
//   i_start_read    start-readout pulse (honoured in IDLE only)
//   i_abort         synchronous abort, effective in any state
//   i_trigger_addr  BRAM address holding the trigger sample
//   i_pretrigger    number of samples stored before the trigger
//   i_next_sample   serialiser consumed the current sample
//   o_ram_addr      BRAM read address
//   o_ram_rd_en     BRAM read enable
//   o_read_active   a valid sample is presented to the serialiser
//   o_sample_index  samples consumed so far (0 .. 2**addr_width)
//   o_read_done     one-cycle completion pulse
interface ram_read_ctrl_if #(
   parameter int addr_width = 12
);
   logic                  i_start_read;
   logic                  i_abort;
   logic [addr_width-1:0] i_trigger_addr;
   logic [addr_width-1:0] i_pretrigger;
   logic                  i_next_sample;
   logic [addr_width-1:0] o_ram_addr;
   logic                  o_ram_rd_en;
   logic                  o_read_active;
   logic [addr_width:0]   o_sample_index;
   logic                  o_read_done;

   modport slave (
      input  i_start_read, i_abort, i_trigger_addr, i_pretrigger, i_next_sample,
      output o_ram_addr, o_ram_rd_en, o_read_active, o_sample_index, o_read_done
   );

   modport master (
      output i_start_read, i_abort, i_trigger_addr, i_pretrigger, i_next_sample,
      input  o_ram_addr, o_ram_rd_en, o_read_active, o_sample_index, o_read_done
   );
endinterface

// File: rtl/ram_read_ctrl.sv
// ram_read_ctrl -- walks the circular sample BRAM from the oldest pre-trigger
// sample to the newest, one sample per serialiser request, and pulses
// o_read_done once all 2**addr_width entries have been consumed.
//
// Ports
//   i_clk_ILA  ILA clock, rising edge
//   i_reset    synchronous, active-low reset (behaves like an abort)
//   bus        ram_read_ctrl_if.slave -- controls in, BRAM/serialiser outputs
module ram_read_ctrl #(
   parameter int addr_width = 12
) (
   input  logic           i_clk_ILA,
   input  logic           i_reset,
   ram_read_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      FILL,
      ACTIVE,
      FETCH
   } state_t;

   // Count value just before the last sample is consumed.
   localparam logic [addr_width:0] last_count = {1'b0, {addr_width{1'b1}}};

   state_t                state_q, state_nxt;
   logic [addr_width-1:0] addr_q, addr_nxt;
   logic [addr_width:0]   count_q, count_nxt;
   logic                  done_q, done_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge i_clk_ILA) begin
      if (!i_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         addr_q  <= addr_nxt;
         count_q <= count_nxt;
         done_q  <= done_nxt;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state_q;
      addr_nxt  = addr_q;
      count_nxt = count_q;
      done_nxt  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Clearing here also drops the final count one cycle after done.
            count_nxt = '0;
            if (bus.i_start_read) begin
               // Wraps naturally to the top of the buffer when pretrigger > trigger.
               addr_nxt  = bus.i_trigger_addr - bus.i_pretrigger;
               state_nxt = PRIME;
            end
         end
         PRIME:  state_nxt = FILL;
         FILL:   state_nxt = ACTIVE;
         ACTIVE: begin
            if (bus.i_next_sample) begin
               count_nxt = count_q + 1'b1;
               if (count_q == last_count) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  addr_nxt  = addr_q + 1'b1;
                  state_nxt = FETCH;
               end
            end
         end
         // Requests arriving while the BRAM output updates are dropped.
         FETCH:   state_nxt = ACTIVE;
         default: state_nxt = IDLE;
      endcase

      // Abort overrides everything, including a coincident final request.
      if (bus.i_abort) begin
         state_nxt = IDLE;
         count_nxt = '0;
         done_nxt  = 1'b0;
      end
   end

   assign bus.o_ram_addr     = (state_q == IDLE) ? '0 : addr_q;
   assign bus.o_ram_rd_en    = (state_q == PRIME) || (state_q == FETCH);
   assign bus.o_read_active  = (state_q == ACTIVE) || (state_q == FETCH);
   assign bus.o_sample_index = count_q;
   assign bus.o_read_done    = done_q;

endmodule

// File: tb/tb_ram_read_ctrl.sv
// tb_ram_read_ctrl -- directed bench for ram_read_ctrl with addr_width = 4.
// A table of {trigger, pretrigger, expected start, request gap} records drives
// full readouts; hand-written sequences cover ignored requests, abort and
// reset mid-readout. A registered BRAM model checks data order.
module tb_ram_read_ctrl;

   localparam int aw    = 4;
   localparam int depth = 1 << aw;

   logic i_clk_ILA = 1'b0;
   logic i_reset   = 1'b0;

   ram_read_ctrl_if #(.addr_width(aw)) bus ();

   ram_read_ctrl #(.addr_width(aw)) dut (
      .i_clk_ILA (i_clk_ILA),
      .i_reset   (i_reset),
      .bus       (bus)
   );

   always #5 i_clk_ILA = ~i_clk_ILA;

   // Registered-output BRAM model
   logic [7:0] mem [depth];
   logic [7:0] ram_dout;

   always @(posedge i_clk_ILA) begin
      if (bus.o_ram_rd_en) ram_dout <= mem[bus.o_ram_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge i_clk_ILA);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {bus.o_ram_addr, bus.o_ram_rd_en, bus.o_read_active,
                   bus.o_sample_index, bus.o_read_done}, 32'd0);
   endtask

   // Start pulse now (cycle 0), then walk to ACTIVE at cycle 3.
   task automatic start_readout(input logic [aw-1:0] trig, input logic [aw-1:0] pre,
                                input logic [aw-1:0] exp_start);
      bus.i_trigger_addr = trig;
      bus.i_pretrigger   = pre;
      bus.i_start_read   = 1'b1;
      step();
      bus.i_start_read = 1'b0;
      check("prime_addr", bus.o_ram_addr, exp_start);
      check("prime_rd_en", bus.o_ram_rd_en, 1);
      check("prime_active", bus.o_read_active, 0);
      check("prime_index", bus.o_sample_index, 0);
      step();
      check("fill_rd_en", bus.o_ram_rd_en, 0);
      check("fill_active", bus.o_read_active, 0);
      step();
      check("active_rise", bus.o_read_active, 1);
      check("first_data", ram_dout, mem[exp_start]);
   endtask

   // One request with no checks; leaves the DUT in ACTIVE ready for the next.
   task automatic advance();
      bus.i_next_sample = 1'b1;
      step();
      bus.i_next_sample = 1'b0;
      step();
      step();
   endtask

   task automatic full_readout(input logic [aw-1:0] trig, input logic [aw-1:0] pre,
                               input logic [aw-1:0] exp_start, input int gap);
      logic [aw-1:0] exp_addr;
      start_readout(trig, pre, exp_start);
      exp_addr = exp_start;
      for (int k = 1; k <= depth; k++) begin
         bus.i_next_sample = 1'b1;
         step();
         bus.i_next_sample = 1'b0;
         if (k < depth) begin
            exp_addr = exp_addr + 1'b1;
            check("fetch_addr", bus.o_ram_addr, exp_addr);
            check("fetch_rd_en", bus.o_ram_rd_en, 1);
            check("fetch_active", bus.o_read_active, 1);
            check("fetch_index", bus.o_sample_index, k);
            check("fetch_done", bus.o_read_done, 0);
            step();
            check("sample_data", ram_dout, mem[exp_addr]);
            check("sample_active", bus.o_read_active, 1);
            repeat (gap - 2) step();
         end else begin
            check("done_pulse", bus.o_read_done, 1);
            check("done_active", bus.o_read_active, 0);
            check("done_index", bus.o_sample_index, depth);
            check("done_rd_en", bus.o_ram_rd_en, 0);
            step();
            check("done_width", bus.o_read_done, 0);
            check_all_zero("post_done_idle");
         end
      end
   endtask

   typedef struct {
      logic [aw-1:0] trig;
      logic [aw-1:0] pre;
      logic [aw-1:0] exp_start;
      int            gap;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < depth; i++) mem[i] = 8'(i * 37 + 11);

      vecs[0] = '{trig: 4'd5,  pre: 4'd3,  exp_start: 4'd2,  gap: 3}; // basic
      vecs[1] = '{trig: 4'd1,  pre: 4'd4,  exp_start: 4'd13, gap: 3}; // wrap at start
      vecs[2] = '{trig: 4'd9,  pre: 4'd0,  exp_start: 4'd9,  gap: 4}; // no pretrigger
      vecs[3] = '{trig: 4'd0,  pre: 4'd15, exp_start: 4'd1,  gap: 3}; // pre > trig
      vecs[4] = '{trig: 4'd15, pre: 4'd15, exp_start: 4'd0,  gap: 5};

      bus.i_start_read   = 1'b0;
      bus.i_abort        = 1'b0;
      bus.i_trigger_addr = '0;
      bus.i_pretrigger   = '0;
      bus.i_next_sample  = 1'b0;

      step();
      step();
      check_all_zero("reset_state");
      i_reset = 1'b1;
      step();
      check_all_zero("idle_after_reset");

      for (int v = 0; v < 5; v++)
         full_readout(vecs[v].trig, vecs[v].pre, vecs[v].exp_start, vecs[v].gap);

      // Requests during PRIME/FILL are ignored.
      bus.i_trigger_addr = 4'd5;
      bus.i_pretrigger   = 4'd3;
      bus.i_start_read   = 1'b1;
      step();
      bus.i_start_read  = 1'b0;
      bus.i_next_sample = 1'b1;
      step();
      step();
      bus.i_next_sample = 1'b0;
      check("fill_ignore_addr", bus.o_ram_addr, 2);
      check("fill_ignore_index", bus.o_sample_index, 0);
      check("fill_ignore_active", bus.o_read_active, 1);

      // Start pulse while ACTIVE changes nothing.
      bus.i_trigger_addr = 4'd10;
      bus.i_pretrigger   = 4'd0;
      bus.i_start_read   = 1'b1;
      step();
      bus.i_start_read = 1'b0;
      check("start_ignore_addr", bus.o_ram_addr, 2);
      check("start_ignore_active", bus.o_read_active, 1);
      check("start_ignore_rd_en", bus.o_ram_rd_en, 0);

      // Request held through ACTIVE and FETCH counts once.
      bus.i_next_sample = 1'b1;
      step();
      step();
      bus.i_next_sample = 1'b0;
      check("fetch_ignore_addr", bus.o_ram_addr, 3);
      check("fetch_ignore_index", bus.o_sample_index, 1);
      check("fetch_ignore_rd_en", bus.o_ram_rd_en, 0);

      // Six more samples to reach 7, then abort coincident with a request.
      repeat (6) advance();
      check("pre_abort_index", bus.o_sample_index, 7);
      check("pre_abort_addr", bus.o_ram_addr, 9);
      bus.i_abort       = 1'b1;
      bus.i_next_sample = 1'b1;
      step();
      bus.i_abort       = 1'b0;
      bus.i_next_sample = 1'b0;
      check_all_zero("abort_outputs");
      step();
      check("abort_no_done", bus.o_read_done, 0);
      check_all_zero("abort_idle");

      // Clean restart after abort.
      full_readout(4'd5, 4'd3, 4'd2, 3);

      // Reset for one cycle during ACTIVE.
      start_readout(4'd7, 4'd2, 4'd5);
      advance();
      advance();
      check("pre_reset_index", bus.o_sample_index, 2);
      i_reset = 1'b0;
      step();
      i_reset = 1'b1;
      check_all_zero("reset_mid_outputs");
      step();
      check_all_zero("reset_mid_idle");
      bus.i_next_sample = 1'b1;
      step();
      bus.i_next_sample = 1'b0;
      check_all_zero("reset_idle_ignores_next");

      full_readout(4'd7, 4'd2, 4'd5, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
